i281_exec_ctrl: RTL and testbench

- Run/debug sequencer for the i281 single-cycle datapath.
- Gates the datapath clock enable (PC, register file, flags, data-memory writes) to provide run, halt, single-step and PC breakpoint control.
- Provides a handshaked loader that writes code memory while the CPU is stopped.
- Sits between the board switches/UART front end and the top-level datapath; counts retired instructions.

---
 rtl/i281_pkg.sv | 17 +
 rtl/i281_load_port.sv | 38 +++
 rtl/i281_exec_ctrl.sv | 120 ++++++++++++
 tb/tb_i281_exec_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i281_pkg.sv
// i281 run/debug sequencer shared definitions.
// State encodings are visible on the state output port.
package i281_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 16;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [2:0] {
        ST_HALT  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STEP  = 3'd2,
        ST_BREAK = 3'd3,
        ST_LOAD  = 3'd4
    } state_e;

endpackage

// File: rtl/i281_load_port.sv
// Registered code-memory write port for the i281 loader.
// One accepted beat becomes a single-cycle write on the next clock.
module i281_load_port
    import i281_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_load,
    input  logic              load_valid,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              code_we,
    output logic [ADDR_W-1:0] code_waddr,
    output logic [DATA_W-1:0] code_wdata
);

    logic accept;

    assign accept = in_load && load_valid;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            code_we    <= 1'b0;
            code_waddr <= '0;
            code_wdata <= '0;
        end else begin
            code_we <= accept;
            if (accept) begin
                code_waddr <= load_addr;
                code_wdata <= load_data;
            end
        end
    end

endmodule

// File: rtl/i281_exec_ctrl.sv
// i281 run/halt/step/breakpoint sequencer with code loader.
// Gates the datapath enable and counts retired instructions.
module i281_exec_ctrl
    import i281_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run_req,
    input  logic              step_req,
    input  logic              halt_req,
    input  logic              bkpt_en,
    input  logic [ADDR_W-1:0] bkpt_addr,
    input  logic [ADDR_W-1:0] pc,
    input  logic              load_start,
    input  logic              load_end,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              cpu_en,
    output logic              code_we,
    output logic [ADDR_W-1:0] code_waddr,
    output logic [DATA_W-1:0] code_wdata,
    output logic [2:0]        state,
    output logic [CNT_W-1:0]  retired
);

    state_e state_q;
    state_e state_d;
    logic   skip_bkpt;
    logic   skip_set;
    logic   bkpt_hit;
    logic   in_load;

    assign in_load    = (state_q == ST_LOAD);
    assign load_ready = in_load;
    assign state      = state_q;

    assign bkpt_hit = (state_q == ST_RUN) && bkpt_en &&
                      (pc == bkpt_addr) && !skip_bkpt;

    always_comb begin
        state_d  = state_q;
        cpu_en   = 1'b0;
        skip_set = 1'b0;
        case (state_q)
            ST_HALT, ST_BREAK: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                end else if (step_req) begin
                    state_d  = ST_STEP;
                    skip_set = (state_q == ST_BREAK);
                end else if (run_req) begin
                    state_d  = ST_RUN;
                    skip_set = (state_q == ST_BREAK);
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (bkpt_hit) begin
                    state_d = ST_BREAK;
                end else begin
                    cpu_en = 1'b1;
                end
            end
            ST_STEP: begin
                cpu_en  = 1'b1;
                state_d = ST_HALT;
            end
            ST_LOAD: begin
                if (load_end) begin
                    state_d = ST_HALT;
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_HALT;
            skip_bkpt <= 1'b0;
            retired   <= '0;
        end else begin
            state_q <= state_d;
            // skip only ever arms while stopped, so it cannot race the clear
            if (cpu_en) begin
                skip_bkpt <= 1'b0;
            end else if (skip_set) begin
                skip_bkpt <= 1'b1;
            end
            if (state_d == ST_LOAD && !in_load) begin
                retired <= '0;
            end else if (cpu_en) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    i281_load_port #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_load_port (
        .clock      (clock),
        .reset      (reset),
        .in_load    (in_load),
        .load_valid (load_valid),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .code_we    (code_we),
        .code_waddr (code_waddr),
        .code_wdata (code_wdata)
    );

endmodule

// File: tb/tb_i281_exec_ctrl.sv
// Testbench for i281_exec_ctrl: vector table, directed corner cases,
// and a randomized run against a behavioural sequencer model.
module tb_i281_exec_ctrl;

    logic        clock;
    logic        reset;
    logic        run_req, step_req, halt_req, bkpt_en;
    logic [5:0]  bkpt_addr, pc, load_addr;
    logic        load_start, load_end, load_valid, load_ready;
    logic [15:0] load_data;
    logic        cpu_en, code_we;
    logic [5:0]  code_waddr;
    logic [15:0] code_wdata;
    logic [2:0]  state;
    logic [15:0] retired;

    int checks = 0;
    int errors = 0;

    i281_exec_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .run_req    (run_req),
        .step_req   (step_req),
        .halt_req   (halt_req),
        .bkpt_en    (bkpt_en),
        .bkpt_addr  (bkpt_addr),
        .pc         (pc),
        .load_start (load_start),
        .load_end   (load_end),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .cpu_en     (cpu_en),
        .code_we    (code_we),
        .code_waddr (code_waddr),
        .code_wdata (code_wdata),
        .state      (state),
        .retired    (retired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [6:0]  req;
        logic [5:0]  baddr;
        logic [5:0]  pcv;
        logic [5:0]  laddr;
        logic [15:0] ldata;
        logic        e_en;
        logic [2:0]  e_st;
        logic [15:0] e_ret;
        logic        e_rdy;
        logic        e_we;
        logic [5:0]  e_wa;
        logic [15:0] e_wd;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        run_req = 0; step_req = 0; halt_req = 0; bkpt_en = 0;
        bkpt_addr = 0; pc = 0; load_start = 0; load_end = 0;
        load_valid = 0; load_addr = 0; load_data = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    // req = {run, step, halt, load_start, load_end, load_valid, bkpt_en}
    function automatic vec_t mk(input logic [6:0] req, input logic [5:0] ba,
                                input logic [5:0] p, input logic [5:0] la,
                                input logic [15:0] ld, input logic en,
                                input logic [2:0] st, input logic [15:0] rt,
                                input logic rdy, input logic we,
                                input logic [5:0] wa, input logic [15:0] wd);
        vec_t v;
        v.req = req; v.baddr = ba; v.pcv = p; v.laddr = la; v.ldata = ld;
        v.e_en = en; v.e_st = st; v.e_ret = rt; v.e_rdy = rdy;
        v.e_we = we; v.e_wa = wa; v.e_wd = wd;
        return v;
    endfunction

    // behavioural model state (modes numbered as the state port reports)
    int          m_mode;
    logic        m_skip;
    logic [15:0] m_ret;
    logic        m_pv;
    logic [5:0]  m_pa;
    logic [15:0] m_pd;

    initial begin
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        #4;
        chk("rst_state", state, 0);
        chk("rst_cpu_en", cpu_en, 0);
        chk("rst_retired", retired, 0);
        chk("rst_we", code_we, 0);
        chk("rst_waddr", code_waddr, 0);
        chk("rst_wdata", code_wdata, 0);
        chk("rst_ready", load_ready, 0);
        tick();
        reset = 1'b1;

        tbl.push_back(mk(7'b0000000, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(7'b0100000, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(7'b0000000, 0, 0, 0, 16'h0, 1, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(7'b0000000, 0, 1, 0, 16'h0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(7'b0100000, 0, 1, 0, 16'h0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(7'b1000000, 0, 1, 0, 16'h0, 1, 2, 1, 0, 0, 0, 0));
        tbl.push_back(mk(7'b0000000, 0, 2, 0, 16'h0, 0, 0, 2, 0, 0, 0, 0));
        tbl.push_back(mk(7'b0000010, 0, 2, 7, 16'h1234, 0, 0, 2, 0, 0, 0, 0));
        tbl.push_back(mk(7'b0000000, 0, 2, 0, 16'h0, 0, 0, 2, 0, 0, 0, 0));
        tbl.push_back(mk(7'b0001000, 0, 2, 0, 16'h0, 0, 0, 2, 0, 0, 0, 0));
        tbl.push_back(mk(7'b0000010, 0, 2, 0, 16'hA001, 0, 4, 0, 1, 0, 0, 0));
        tbl.push_back(mk(7'b0000010, 0, 2, 1, 16'hA002, 0, 4, 0, 1, 1, 0, 16'hA001));
        tbl.push_back(mk(7'b0000110, 0, 2, 2, 16'hA003, 0, 4, 0, 1, 1, 1, 16'hA002));
        tbl.push_back(mk(7'b0000000, 0, 2, 0, 16'h0, 0, 0, 0, 0, 1, 2, 16'hA003));
        tbl.push_back(mk(7'b0000000, 0, 2, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(7'b1010000, 0, 3, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(7'b0010001, 3, 3, 0, 16'h0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(7'b0000000, 3, 3, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(7'b1000000, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(7'b0000001, 2, 1, 0, 16'h0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(7'b0000001, 2, 2, 0, 16'h0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(7'b0100001, 2, 2, 0, 16'h0, 0, 3, 1, 0, 0, 0, 0));
        tbl.push_back(mk(7'b0000001, 2, 2, 0, 16'h0, 1, 2, 1, 0, 0, 0, 0));
        tbl.push_back(mk(7'b0010000, 2, 3, 0, 16'h0, 0, 0, 2, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            {run_req, step_req, halt_req, load_start,
             load_end, load_valid, bkpt_en} = tbl[i].req;
            bkpt_addr = tbl[i].baddr;
            pc        = tbl[i].pcv;
            load_addr = tbl[i].laddr;
            load_data = tbl[i].ldata;
            #4;
            chk($sformatf("v%0d_en", i), cpu_en, tbl[i].e_en);
            chk($sformatf("v%0d_state", i), state, tbl[i].e_st);
            chk($sformatf("v%0d_ret", i), retired, tbl[i].e_ret);
            chk($sformatf("v%0d_ready", i), load_ready, tbl[i].e_rdy);
            chk($sformatf("v%0d_we", i), code_we, tbl[i].e_we);
            if (tbl[i].e_we) begin
                chk($sformatf("v%0d_waddr", i), code_waddr, tbl[i].e_wa);
                chk($sformatf("v%0d_wdata", i), code_wdata, tbl[i].e_wd);
            end
            tick();
        end
        idle_inputs();

        // breakpoint at 5 with a datapath advancing pc per enabled cycle
        do_reset();
        bkpt_en = 1; bkpt_addr = 5; pc = 0; run_req = 1;
        tick();
        run_req = 0;
        for (int i = 0; i < 20; i++) begin
            #4;
            if (cpu_en !== 1'b1) break;
            tick();
            pc = pc + 1;
        end
        chk("bk_stop_pc", pc, 5);
        chk("bk_stop_en", cpu_en, 0);
        tick();
        #4;
        chk("bk_state", state, 3);
        chk("bk_retired", retired, 5);
        chk("bk_hold_en", cpu_en, 0);
        tick();
        run_req = 1;
        tick();
        run_req = 0;
        #4;
        chk("bk_resume_state", state, 1);
        chk("bk_resume_en", cpu_en, 1);
        tick();
        pc = 6;
        #4;
        chk("bk_past_en", cpu_en, 1);
        chk("bk_past_ret", retired, 6);
        for (int i = 0; i < 10 && retired != 16'd9; i++) begin
            tick();
            pc = pc + 1;
        end
        chk("mid_ret9", retired, 9);
        #3;
        reset = 1'b0;
        #1;
        chk("async_en", cpu_en, 0);
        chk("async_state", state, 0);
        chk("async_ret", retired, 0);
        tick();
        reset = 1'b1;
        idle_inputs();

        // randomized run against the model
        do_reset();
        m_mode = 0; m_skip = 0; m_ret = 0; m_pv = 0; m_pa = 0; m_pd = 0;
        bkpt_addr = 6'($urandom_range(0, 20));
        for (int c = 0; c < 3000; c++) begin
            logic hit, en;
            int   nx;
            run_req    = ($urandom_range(0, 5) == 0);
            step_req   = ($urandom_range(0, 9) == 0);
            halt_req   = ($urandom_range(0, 11) == 0);
            load_start = ($urandom_range(0, 29) == 0);
            load_end   = ($urandom_range(0, 5) == 0);
            load_valid = ($urandom_range(0, 1) == 0);
            bkpt_en    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0)
                bkpt_addr = 6'($urandom_range(0, 63));
            load_addr = 6'($urandom);
            load_data = 16'($urandom);
            #4;
            hit = (m_mode == 1) && bkpt_en && (pc == bkpt_addr) && !m_skip;
            en  = (m_mode == 2) || (m_mode == 1 && !halt_req && !hit);
            chk("rnd_en", cpu_en, en);
            chk("rnd_state", state, m_mode);
            chk("rnd_ret", retired, m_ret);
            chk("rnd_ready", load_ready, m_mode == 4);
            chk("rnd_we", code_we, m_pv);
            if (m_pv) begin
                chk("rnd_waddr", code_waddr, m_pa);
                chk("rnd_wdata", code_wdata, m_pd);
            end
            nx = m_mode;
            if (m_mode == 0 || m_mode == 3) begin
                if (load_start) nx = 4;
                else if (step_req) nx = 2;
                else if (run_req) nx = 1;
                if (m_mode == 3 && (nx == 1 || nx == 2)) m_skip = 1;
            end else if (m_mode == 1) begin
                if (halt_req) nx = 0;
                else if (hit) nx = 3;
            end else if (m_mode == 2) begin
                nx = 0;
            end else if (load_end) begin
                nx = 0;
            end
            if (en) begin
                m_ret  = m_ret + 1;
                m_skip = 0;
            end
            if (nx == 4 && m_mode != 4) m_ret = 0;
            m_pv = (m_mode == 4) && load_valid;
            if (m_pv) begin
                m_pa = load_addr;
                m_pd = load_data;
            end
            m_mode = nx;
            tick();
            if (en) pc = pc + 1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
